// File: rtl/controle_noite.sv
// Night-phase sequencer: grants the target selector to wolf, seer and doctor in turn, then resolves the victim.
// Optional NOITE_TIMEOUT_EN adds a per-turn timeout counter and the timeout pulse.
module controle_noite #(
  parameter int N_JOGADORES    = 8,
  parameter int TIMEOUT_CICLOS = 1000,
  localparam int W             = $clog2(N_JOGADORES)
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   inicia_noite,
  input  logic [2:0]             papel_vivo,
  input  logic [N_JOGADORES-1:0] vivos,
  input  logic [W-1:0]           alvo,
  input  logic                   passa,
  output logic [1:0]             turno,
  output logic [W-1:0]           revela_idx,
  output logic                   revela_pulso,
  output logic [W-1:0]           vitima,
  output logic                   vitima_valida,
  output logic [W-1:0]           protegido,
  output logic                   timeout,
  output logic                   fim_noite,
  output logic [4:0]             db_estado
);

  typedef enum logic [3:0] {
    OCIOSO        = 4'd0,
    TURNO_LOBO    = 4'd1,
    REG_LOBO      = 4'd2,
    TURNO_VIDENTE = 4'd3,
    REG_VIDENTE   = 4'd4,
    TURNO_MEDICO  = 4'd5,
    REG_MEDICO    = 4'd6,
    RESOLVE       = 4'd7,
    FIM           = 4'd8
  } estado_t;

  estado_t        estado_r;
  logic           flag_lobo_r, flag_medico_r;
  logic [W-1:0]   vitima_r, protegido_r, revela_idx_r;
  logic           vitima_valida_r, revela_pulso_r, timeout_r, fim_noite_r;
  logic           em_turno_s, passa_ok_s, expira_s;

  // apos: 0 = night start, 1 = after wolf, 2 = after seer, 3 = after doctor
  function automatic estado_t proximo(input logic [1:0] apos, input logic [2:0] pv);
    if (apos == 2'd0 && pv[0])       return TURNO_LOBO;
    else if (apos <= 2'd1 && pv[1])  return TURNO_VIDENTE;
    else if (apos <= 2'd2 && pv[2])  return TURNO_MEDICO;
    else                             return RESOLVE;
  endfunction

  // Turn state and validity of the current confirmation
  always_comb begin
    em_turno_s = 1'b0;
    passa_ok_s = 1'b0;
    if (estado_r == TURNO_LOBO || estado_r == TURNO_VIDENTE || estado_r == TURNO_MEDICO) begin
      em_turno_s = 1'b1;
    end else begin
      em_turno_s = 1'b0;
    end
    if (passa && em_turno_s && ({1'b0, alvo} < (W+1)'(N_JOGADORES))) begin
      passa_ok_s = vivos[alvo];
    end else begin
      passa_ok_s = 1'b0;
    end
  end

`ifdef NOITE_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CICLOS);
  logic [CW-1:0] cnt_r;

  // Per-turn cycle counter; restarts whenever a turn is left or not active
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_r <= '0;
    end else if (!em_turno_s || passa_ok_s || expira_s) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign expira_s = em_turno_s && (cnt_r == CW'(TIMEOUT_CICLOS - 1));
`else
  assign expira_s = 1'b0;
`endif

  // Night sequencer with registered results and strobes
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_r        <= OCIOSO;
      flag_lobo_r     <= 1'b0;
      flag_medico_r   <= 1'b0;
      vitima_r        <= '0;
      protegido_r     <= '0;
      revela_idx_r    <= '0;
      vitima_valida_r <= 1'b0;
      revela_pulso_r  <= 1'b0;
      timeout_r       <= 1'b0;
      fim_noite_r     <= 1'b0;
    end else begin
      revela_pulso_r <= 1'b0;
      timeout_r      <= 1'b0;
      fim_noite_r    <= 1'b0;
      case (estado_r)
        OCIOSO: begin
          if (inicia_noite) begin
            flag_lobo_r     <= 1'b0;
            flag_medico_r   <= 1'b0;
            vitima_valida_r <= 1'b0;
            estado_r        <= proximo(2'd0, papel_vivo);
          end
        end
        TURNO_LOBO: begin
          if (passa_ok_s) begin
            vitima_r <= alvo;
            estado_r <= REG_LOBO;
          end else if (expira_s) begin
            timeout_r <= 1'b1;
            estado_r  <= proximo(2'd1, papel_vivo);
          end
        end
        REG_LOBO: begin
          flag_lobo_r <= 1'b1;
          estado_r    <= proximo(2'd1, papel_vivo);
        end
        TURNO_VIDENTE: begin
          if (passa_ok_s) begin
            revela_idx_r   <= alvo;
            revela_pulso_r <= 1'b1;
            estado_r       <= REG_VIDENTE;
          end else if (expira_s) begin
            timeout_r <= 1'b1;
            estado_r  <= proximo(2'd2, papel_vivo);
          end
        end
        REG_VIDENTE: estado_r <= proximo(2'd2, papel_vivo);
        TURNO_MEDICO: begin
          if (passa_ok_s) begin
            protegido_r <= alvo;
            estado_r    <= REG_MEDICO;
          end else if (expira_s) begin
            timeout_r <= 1'b1;
            estado_r  <= RESOLVE;
          end
        end
        REG_MEDICO: begin
          flag_medico_r <= 1'b1;
          estado_r      <= RESOLVE;
        end
        RESOLVE: begin
          vitima_valida_r <= flag_lobo_r & ~(flag_medico_r & (protegido_r == vitima_r));
          fim_noite_r     <= 1'b1;
          estado_r        <= FIM;
        end
        FIM:     estado_r <= OCIOSO;
        default: estado_r <= OCIOSO;
      endcase
    end
  end

  // State decode for the turn indicator and debug code
  always_comb begin
    turno     = 2'd0;
    db_estado = 5'b11111;
    case (estado_r)
      TURNO_LOBO, REG_LOBO:         turno = 2'd1;
      TURNO_VIDENTE, REG_VIDENTE:   turno = 2'd2;
      TURNO_MEDICO, REG_MEDICO:     turno = 2'd3;
      default:                      turno = 2'd0;
    endcase
    case (estado_r)
      OCIOSO, TURNO_LOBO, REG_LOBO, TURNO_VIDENTE, REG_VIDENTE,
      TURNO_MEDICO, REG_MEDICO, RESOLVE, FIM: db_estado = {1'b0, estado_r};
      default:                                db_estado = 5'b11111;
    endcase
  end

  assign revela_idx    = revela_idx_r;
  assign revela_pulso  = revela_pulso_r;
  assign vitima        = vitima_r;
  assign vitima_valida = vitima_valida_r;
  assign protegido     = protegido_r;
  assign timeout       = timeout_r;
  assign fim_noite     = fim_noite_r;

endmodule

// File: tb/tb_controle_noite.sv
// Directed self-checking bench for controle_noite (N=8, TIMEOUT=16).
module tb_controle_noite;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       inicia_noite = 1'b0;
  logic       passa = 1'b0;
  logic [2:0] papel_vivo = 3'b000;
  logic [7:0] vivos = 8'hFF;
  logic [2:0] alvo = 3'd0;
  logic [1:0] turno;
  logic [2:0] revela_idx, vitima, protegido;
  logic       revela_pulso, vitima_valida, timeout, fim_noite;
  logic [4:0] db_estado;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int c0 = 0;

  controle_noite #(.N_JOGADORES(8), .TIMEOUT_CICLOS(16)) dut (
    .clock(clock), .reset_n(reset_n), .inicia_noite(inicia_noite),
    .papel_vivo(papel_vivo), .vivos(vivos), .alvo(alvo), .passa(passa),
    .turno(turno), .revela_idx(revela_idx), .revela_pulso(revela_pulso),
    .vitima(vitima), .vitima_valida(vitima_valida), .protegido(protegido),
    .timeout(timeout), .fim_noite(fim_noite), .db_estado(db_estado)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #12;
    n_vec++; if ({db_estado, turno, vitima, vitima_valida, protegido, revela_idx, revela_pulso, timeout, fim_noite} !== 21'd0) begin
      n_err++; $display("FAIL reset_outputs: got db=%0d turno=%0d vit=%0d vv=%0d prot=%0d rev=%0d want all 0", db_estado, turno, vitima, vitima_valida, protegido, revela_idx); end
    reset_n = 1'b1;
    tick();
    n_vec++; if (db_estado !== 5'd0) begin n_err++; $display("FAIL reset_idle: got %0d want 0", db_estado); end
  endtask

  task automatic test_full_night();
    papel_vivo = 3'b111; vivos = 8'hFF;
    inicia_noite = 1'b1; c0 = cyc; tick(); inicia_noite = 1'b0;
    n_vec++; if ({db_estado, turno} !== {5'd1, 2'd1}) begin n_err++; $display("FAIL full_lobo: got db=%0d turno=%0d want 1/1", db_estado, turno); end
    alvo = 3'd3; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, vitima} !== {5'd2, 3'd3}) begin n_err++; $display("FAIL full_reg_lobo: got db=%0d vit=%0d want 2/3", db_estado, vitima); end
    tick();
    n_vec++; if ({db_estado, turno} !== {5'd3, 2'd2}) begin n_err++; $display("FAIL full_vidente: got db=%0d turno=%0d want 3/2", db_estado, turno); end
    alvo = 3'd5; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, revela_pulso, revela_idx} !== {5'd4, 1'b1, 3'd5}) begin n_err++; $display("FAIL full_revela: got db=%0d pulso=%0d idx=%0d want 4/1/5", db_estado, revela_pulso, revela_idx); end
    tick();
    n_vec++; if ({db_estado, turno, revela_pulso} !== {5'd5, 2'd3, 1'b0}) begin n_err++; $display("FAIL full_medico: got db=%0d turno=%0d pulso=%0d want 5/3/0", db_estado, turno, revela_pulso); end
    alvo = 3'd1; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, protegido} !== {5'd6, 3'd1}) begin n_err++; $display("FAIL full_reg_medico: got db=%0d prot=%0d want 6/1", db_estado, protegido); end
    tick();
    n_vec++; if ({db_estado, fim_noite} !== {5'd7, 1'b0}) begin n_err++; $display("FAIL full_resolve: got db=%0d fim=%0d want 7/0", db_estado, fim_noite); end
    tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida, vitima} !== {5'd8, 1'b1, 1'b1, 3'd3}) begin n_err++; $display("FAIL full_fim: got db=%0d fim=%0d vv=%0d vit=%0d want 8/1/1/3", db_estado, fim_noite, vitima_valida, vitima); end
    n_vec++; if (cyc - c0 !== 8) begin n_err++; $display("FAIL full_latency: got %0d want 8", cyc - c0); end
    tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida} !== {5'd0, 1'b0, 1'b1}) begin n_err++; $display("FAIL full_back_idle: got db=%0d fim=%0d vv=%0d want 0/0/1", db_estado, fim_noite, vitima_valida); end
  endtask

  task automatic test_doctor_save();
    papel_vivo = 3'b101;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    n_vec++; if ({db_estado, vitima_valida} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL save_start: got db=%0d vv=%0d want 1/0", db_estado, vitima_valida); end
    alvo = 3'd4; passa = 1'b1; tick(); passa = 1'b0;
    tick();
    n_vec++; if (db_estado !== 5'd5) begin n_err++; $display("FAIL save_skip_seer: got %0d want 5", db_estado); end
    passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, protegido} !== {5'd6, 3'd4}) begin n_err++; $display("FAIL save_prot: got db=%0d prot=%0d want 6/4", db_estado, protegido); end
    tick(); tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida, vitima, protegido} !== {5'd8, 1'b1, 1'b0, 3'd4, 3'd4}) begin n_err++; $display("FAIL save_result: got db=%0d fim=%0d vv=%0d vit=%0d prot=%0d want 8/1/0/4/4", db_estado, fim_noite, vitima_valida, vitima, protegido); end
    tick();
  endtask

  task automatic test_dead_target();
    papel_vivo = 3'b001; vivos = 8'hF7;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    alvo = 3'd3; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if (db_estado !== 5'd1) begin n_err++; $display("FAIL dead_ignored: got %0d want 1", db_estado); end
    alvo = 3'd2; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, vitima} !== {5'd2, 3'd2}) begin n_err++; $display("FAIL dead_accept: got db=%0d vit=%0d want 2/2", db_estado, vitima); end
    tick();
    n_vec++; if (db_estado !== 5'd7) begin n_err++; $display("FAIL dead_resolve: got %0d want 7", db_estado); end
    tick();
    n_vec++; if ({fim_noite, vitima_valida, vitima} !== {1'b1, 1'b1, 3'd2}) begin n_err++; $display("FAIL dead_result: got fim=%0d vv=%0d vit=%0d want 1/1/2", fim_noite, vitima_valida, vitima); end
    tick();
    vivos = 8'hFF;
  endtask

`ifdef NOITE_TIMEOUT_EN
  task automatic test_timeout();
    papel_vivo = 3'b101;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    for (int i = 1; i < 16; i++) begin
      n_vec++; if ({db_estado, timeout} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL to_wait_%0d: got db=%0d to=%0d want 1/0", i, db_estado, timeout); end
      tick();
    end
    n_vec++; if ({db_estado, timeout} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL to_last_cycle: got db=%0d to=%0d want 1/0", db_estado, timeout); end
    tick();
    n_vec++; if ({db_estado, turno, timeout} !== {5'd5, 2'd3, 1'b1}) begin n_err++; $display("FAIL to_pulse: got db=%0d turno=%0d to=%0d want 5/3/1", db_estado, turno, timeout); end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_vec++; if ({db_estado, timeout} !== {5'd5, 1'b0}) begin n_err++; $display("FAIL to_doc_wait_%0d: got db=%0d to=%0d want 5/0", i, db_estado, timeout); end
    end
    alvo = 3'd0; passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, timeout, protegido} !== {5'd6, 1'b0, 3'd0}) begin n_err++; $display("FAIL to_passa_wins: got db=%0d to=%0d prot=%0d want 6/0/0", db_estado, timeout, protegido); end
    tick(); tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida} !== {5'd8, 1'b1, 1'b0}) begin n_err++; $display("FAIL to_result: got db=%0d fim=%0d vv=%0d want 8/1/0", db_estado, fim_noite, vitima_valida); end
    tick();
  endtask
`else
  task automatic test_timeout();
    papel_vivo = 3'b001;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    n_vec++; if ({db_estado, timeout} !== {5'd1, 1'b0}) begin n_err++; $display("FAIL nto_wait: got db=%0d to=%0d want 1/0", db_estado, timeout); end
    alvo = 3'd1; passa = 1'b1; tick(); passa = 1'b0;
    tick(); tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida, vitima} !== {5'd8, 1'b1, 1'b1, 3'd1}) begin n_err++; $display("FAIL nto_result: got db=%0d fim=%0d vv=%0d vit=%0d want 8/1/1/1", db_estado, fim_noite, vitima_valida, vitima); end
    tick();
  endtask
`endif

  task automatic test_skip_empty();
    papel_vivo = 3'b000;
    inicia_noite = 1'b1; c0 = cyc; tick(); inicia_noite = 1'b0;
    n_vec++; if ({db_estado, turno} !== {5'd7, 2'd0}) begin n_err++; $display("FAIL empty_resolve: got db=%0d turno=%0d want 7/0", db_estado, turno); end
    tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida} !== {5'd8, 1'b1, 1'b0}) begin n_err++; $display("FAIL empty_fim: got db=%0d fim=%0d vv=%0d want 8/1/0", db_estado, fim_noite, vitima_valida); end
    n_vec++; if (cyc - c0 !== 2) begin n_err++; $display("FAIL empty_latency: got %0d want 2", cyc - c0); end
    tick();
    papel_vivo = 3'b011;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    alvo = 3'd6; passa = 1'b1; tick(); passa = 1'b0;
    tick();
    passa = 1'b1; tick(); passa = 1'b0;
    n_vec++; if ({db_estado, revela_pulso, revela_idx} !== {5'd4, 1'b1, 3'd6}) begin n_err++; $display("FAIL skip_revela: got db=%0d pulso=%0d idx=%0d want 4/1/6", db_estado, revela_pulso, revela_idx); end
    tick();
    n_vec++; if ({db_estado, turno} !== {5'd7, 2'd0}) begin n_err++; $display("FAIL skip_no_doctor: got db=%0d turno=%0d want 7/0", db_estado, turno); end
    tick();
    n_vec++; if ({fim_noite, vitima_valida, vitima} !== {1'b1, 1'b1, 3'd6}) begin n_err++; $display("FAIL skip_result: got fim=%0d vv=%0d vit=%0d want 1/1/6", fim_noite, vitima_valida, vitima); end
    tick();
  endtask

  task automatic test_reset_mid_night();
    papel_vivo = 3'b111;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    alvo = 3'd2; passa = 1'b1; tick(); passa = 1'b0;
    tick();
    n_vec++; if (db_estado !== 5'd3) begin n_err++; $display("FAIL mid_pre: got %0d want 3", db_estado); end
    #1 reset_n = 1'b0;
    #1;
    n_vec++; if ({db_estado, turno, vitima, vitima_valida, protegido, revela_idx, revela_pulso, timeout, fim_noite} !== 21'd0) begin
      n_err++; $display("FAIL mid_reset: got db=%0d turno=%0d vit=%0d vv=%0d prot=%0d rev=%0d fim=%0d want all 0", db_estado, turno, vitima, vitima_valida, protegido, revela_idx, fim_noite); end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if ({db_estado, fim_noite} !== {5'd0, 1'b0}) begin n_err++; $display("FAIL mid_no_fim_%0d: got db=%0d fim=%0d want 0/0", i, db_estado, fim_noite); end
    end
    papel_vivo = 3'b101;
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    alvo = 3'd1; passa = 1'b1; tick(); passa = 1'b0;
    tick();
    inicia_noite = 1'b1; tick(); inicia_noite = 1'b0;
    n_vec++; if ({db_estado, turno} !== {5'd5, 2'd3}) begin n_err++; $display("FAIL mid_inicia_ignored: got db=%0d turno=%0d want 5/3", db_estado, turno); end
    passa = 1'b1; tick(); passa = 1'b0;
    tick(); tick();
    n_vec++; if ({db_estado, fim_noite, vitima_valida, vitima, protegido} !== {5'd8, 1'b1, 1'b0, 3'd1, 3'd1}) begin n_err++; $display("FAIL mid_result: got db=%0d fim=%0d vv=%0d vit=%0d prot=%0d want 8/1/0/1/1", db_estado, fim_noite, vitima_valida, vitima, protegido); end
    tick();
  endtask

  initial begin
    test_reset();
    test_full_night();
    test_doctor_save();
    test_dead_target();
    test_timeout();
    test_skip_empty();
    test_reset_mid_night();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
